mem_arbiter: RTL and testbench

// - Shares one 128-bit block main memory between the instruction cache and data cache.
// - Sits between the cache miss ports of cpu_pipeline and the single memory model.
// - Round-robin grant; whole block transfers are never interleaved.
// - Address, command and write data are latched at grant time.

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide main memory between the I-cache and the D-cache.
// Latency: grant one edge after a request; the cache stall drops in the cycle the memory
//   finishes, followed by one RELEASE cycle before the next grant.
// Backpressure: requesters are held by *_BUSYWAIT until their own transfer is done; memory
//   holds the arbiter with MEM_BUSYWAIT.
//
// Ports:
//   CLK, RESET                     clock (rising edge), asynchronous active-high reset
//   INST_MEM_READ/ADDRESS          I-cache block read request
//   INST_MEM_READDATA/BUSYWAIT     I-cache read block (broadcast) and stall
//   DATA_MEM_READ/WRITE/ADDRESS    D-cache block read / write-back request
//   DATA_MEM_WRITEDATA             D-cache write-back block
//   DATA_MEM_READDATA/BUSYWAIT     D-cache read block (broadcast) and stall
//   MEM_READ/WRITE/ADDRESS/WRITEDATA  registered command, address and data to memory
//   MEM_READDATA/BUSYWAIT          memory read block and busy
//   STAT_I_GRANTS/D_GRANTS/CONFLICTS  saturating counters, present only with ARB_STATS_EN
//
// Optional feature macro: ARB_STATS_EN (grant / conflict statistics counters).
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
`ifdef ARB_STATS_EN
  ,parameter int STAT_W = 32
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              INST_MEM_READ,
  input  logic [ADDR_W-1:0] INST_MEM_ADDRESS,
  output logic [DATA_W-1:0] INST_MEM_READDATA,
  output logic              INST_MEM_BUSYWAIT,
  input  logic              DATA_MEM_READ,
  input  logic              DATA_MEM_WRITE,
  input  logic [ADDR_W-1:0] DATA_MEM_ADDRESS,
  input  logic [DATA_W-1:0] DATA_MEM_WRITEDATA,
  output logic [DATA_W-1:0] DATA_MEM_READDATA,
  output logic              DATA_MEM_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
`ifdef ARB_STATS_EN
  ,output logic [STAT_W-1:0] STAT_I_GRANTS
  ,output logic [STAT_W-1:0] STAT_D_GRANTS
  ,output logic [STAT_W-1:0] STAT_CONFLICTS
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0] r_state;
  logic       r_last_d;   // 1: D-cache owned the previous grant, so I wins the next tie
  logic       r_started;  // memory has acknowledged the current command with busy

  logic w_req_i;
  logic w_req_d;
  logic w_grant_i;
  logic w_grant_d;
  logic w_done;

  assign w_req_i   = INST_MEM_READ;
  assign w_req_d   = DATA_MEM_READ | DATA_MEM_WRITE;
  assign w_grant_i = (r_state == ST_IDLE) && w_req_i && (!w_req_d || r_last_d);
  assign w_grant_d = (r_state == ST_IDLE) && w_req_d && !w_grant_i;
  // Busy low alone is ambiguous before the memory has seen the command; only a
  // busy-high-then-low sequence marks the end of the transfer.
  assign w_done    = r_started && !MEM_BUSYWAIT;

  assign INST_MEM_BUSYWAIT = w_req_i && !((r_state == ST_SERVE_I) && w_done);
  assign DATA_MEM_BUSYWAIT = w_req_d && !((r_state == ST_SERVE_D) && w_done);
  assign INST_MEM_READDATA = MEM_READDATA;
  assign DATA_MEM_READDATA = MEM_READDATA;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= ST_IDLE;
      r_last_d      <= 1'b1;
      r_started     <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_i) begin
            MEM_READ    <= 1'b1;
            MEM_WRITE   <= 1'b0;
            MEM_ADDRESS <= INST_MEM_ADDRESS;
            r_last_d    <= 1'b0;
            r_state     <= ST_SERVE_I;
          end else if (w_grant_d) begin
            // READ and WRITE together: the dirty block is written back first.
            MEM_READ      <= !DATA_MEM_WRITE;
            MEM_WRITE     <= DATA_MEM_WRITE;
            MEM_ADDRESS   <= DATA_MEM_ADDRESS;
            MEM_WRITEDATA <= DATA_MEM_WRITEDATA;
            r_last_d      <= 1'b1;
            r_state       <= ST_SERVE_D;
          end
        end
        ST_SERVE_I, ST_SERVE_D: begin
          if (w_done) begin
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            r_started <= 1'b0;
            r_state   <= ST_RELEASE;
          end else if (MEM_BUSYWAIT) begin
            r_started <= 1'b1;
          end
        end
        // RELEASE: one dead cycle so the finished cache's request is gone before
        // the next arbitration.
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STAT_I_GRANTS  <= '0;
      STAT_D_GRANTS  <= '0;
      STAT_CONFLICTS <= '0;
    end else begin
      if (w_grant_i && (STAT_I_GRANTS != STAT_MAX)) begin
        STAT_I_GRANTS <= STAT_I_GRANTS + 1'b1;
      end
      if (w_grant_d && (STAT_D_GRANTS != STAT_MAX)) begin
        STAT_D_GRANTS <= STAT_D_GRANTS + 1'b1;
      end
      if ((r_state == ST_IDLE) && w_req_i && w_req_d && (STAT_CONFLICTS != STAT_MAX)) begin
        STAT_CONFLICTS <= STAT_CONFLICTS + 1'b1;
      end
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Latency: drives cache requests on the falling edge and samples there as well.
// Backpressure: a simple memory model with programmable busy time answers commands.
module tb_mem_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
`ifdef ARB_STATS_EN
  localparam int TB_STAT_W = 4;
  logic [TB_STAT_W-1:0] STAT_I_GRANTS, STAT_D_GRANTS, STAT_CONFLICTS;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic              INST_MEM_READ;
  logic [ADDR_W-1:0] INST_MEM_ADDRESS;
  logic [DATA_W-1:0] INST_MEM_READDATA;
  logic              INST_MEM_BUSYWAIT;
  logic              DATA_MEM_READ;
  logic              DATA_MEM_WRITE;
  logic [ADDR_W-1:0] DATA_MEM_ADDRESS;
  logic [DATA_W-1:0] DATA_MEM_WRITEDATA;
  logic [DATA_W-1:0] DATA_MEM_READDATA;
  logic              DATA_MEM_BUSYWAIT;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef ARB_STATS_EN
    ,.STAT_W(TB_STAT_W)
`endif
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .INST_MEM_READ(INST_MEM_READ), .INST_MEM_ADDRESS(INST_MEM_ADDRESS),
    .INST_MEM_READDATA(INST_MEM_READDATA), .INST_MEM_BUSYWAIT(INST_MEM_BUSYWAIT),
    .DATA_MEM_READ(DATA_MEM_READ), .DATA_MEM_WRITE(DATA_MEM_WRITE),
    .DATA_MEM_ADDRESS(DATA_MEM_ADDRESS), .DATA_MEM_WRITEDATA(DATA_MEM_WRITEDATA),
    .DATA_MEM_READDATA(DATA_MEM_READDATA), .DATA_MEM_BUSYWAIT(DATA_MEM_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef ARB_STATS_EN
    ,.STAT_I_GRANTS(STAT_I_GRANTS), .STAT_D_GRANTS(STAT_D_GRANTS), .STAT_CONFLICTS(STAT_CONFLICTS)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // Memory model: on a new command, busy rises one edge later and stays high for
  // mem_lat cycles; the access happens when busy falls. It then waits for the
  // command to drop before accepting another.
  logic [DATA_W-1:0] mem_arr [16];
  int   mem_lat = 5;
  int   mm_cnt;
  logic mm_fin;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MEM_BUSYWAIT <= 1'b0;
      MEM_READDATA <= '0;
      mm_fin       <= 1'b0;
      mm_cnt       <= 0;
      for (int k = 0; k < 16; k++) mem_arr[k] <= init_word(k);
    end else if (!(MEM_READ || MEM_WRITE)) begin
      MEM_BUSYWAIT <= 1'b0;
      mm_fin       <= 1'b0;
    end else if (!mm_fin) begin
      if (!MEM_BUSYWAIT) begin
        MEM_BUSYWAIT <= 1'b1;
        mm_cnt       <= mem_lat;
      end else if (mm_cnt <= 1) begin
        MEM_BUSYWAIT <= 1'b0;
        mm_fin       <= 1'b1;
        if (MEM_WRITE) mem_arr[MEM_ADDRESS[3:0]] <= MEM_WRITEDATA;
        else           MEM_READDATA <= mem_arr[MEM_ADDRESS[3:0]];
      end else begin
        mm_cnt <= mm_cnt - 1;
      end
    end
  end

  // Transaction-level reference: who should own the memory, what it should be
  // told, and what each completed read must return.
  logic [DATA_W-1:0] shadow [16];
  int   m_last;       // 0 = I, 1 = D
  int   m_active;     // -1 none, 0 I, 1 D
  logic m_prev_cmd;
  logic [ADDR_W-1:0] m_addr;
  logic m_isread;
  int   i_done_cnt, d_done_cnt;

  task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) shadow[k] = init_word(k);
    m_last = 1; m_active = -1; m_prev_cmd = 1'b0;
  endtask

  task automatic monitor();
    logic cmd, ri, rd;
    int side;
    cmd = MEM_READ | MEM_WRITE;
    ri  = INST_MEM_READ;
    rd  = DATA_MEM_READ | DATA_MEM_WRITE;
    if (cmd && !m_prev_cmd) begin
      check("grant_has_request", ri | rd, 1);
      side = (ri && rd) ? (m_last == 0 ? 1 : 0) : (ri ? 0 : 1);
      if (side == 0) begin
        check("grant_i_read", MEM_READ, 1);
        check("grant_i_write", MEM_WRITE, 0);
        check("grant_i_addr", MEM_ADDRESS, INST_MEM_ADDRESS);
        m_addr = INST_MEM_ADDRESS; m_isread = 1'b1;
      end else begin
        check("grant_d_write", MEM_WRITE, DATA_MEM_WRITE);
        check("grant_d_read", MEM_READ, !DATA_MEM_WRITE);
        check("grant_d_addr", MEM_ADDRESS, DATA_MEM_ADDRESS);
        m_addr = DATA_MEM_ADDRESS; m_isread = !DATA_MEM_WRITE;
        if (DATA_MEM_WRITE) begin
          check("grant_d_wdata", MEM_WRITEDATA, DATA_MEM_WRITEDATA);
          shadow[DATA_MEM_ADDRESS[3:0]] = DATA_MEM_WRITEDATA;
        end
      end
      m_last = side; m_active = side;
    end
    if (ri && !INST_MEM_BUSYWAIT) begin
      check("i_done_owner", m_active, 0);
      check("i_readdata", INST_MEM_READDATA, shadow[m_addr[3:0]]);
      m_active = -1; i_done_cnt++;
    end
    if (!ri) check("i_idle_nostall", INST_MEM_BUSYWAIT, 0);
    if (rd && !DATA_MEM_BUSYWAIT) begin
      check("d_done_owner", m_active, 1);
      if (m_isread) check("d_readdata", DATA_MEM_READDATA, shadow[m_addr[3:0]]);
      m_active = -1; d_done_cnt++;
    end
    if (!rd) check("d_idle_nostall", DATA_MEM_BUSYWAIT, 0);
    m_prev_cmd = cmd;
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
  endtask

  task automatic drop_done();
    if (INST_MEM_READ && !INST_MEM_BUSYWAIT) INST_MEM_READ = 1'b0;
    if ((DATA_MEM_READ || DATA_MEM_WRITE) && !DATA_MEM_BUSYWAIT) begin
      DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0;
    end
  endtask

  task automatic run_until_idle();
    int n = 0;
    while ((INST_MEM_READ || DATA_MEM_READ || DATA_MEM_WRITE) && n < 400) begin
      tick(); drop_done(); n++;
    end
    check("drain_bound", n < 400, 1);
    tick(); tick();
  endtask

  task automatic clear_inputs();
    INST_MEM_READ = 1'b0; INST_MEM_ADDRESS = '0;
    DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0;
    DATA_MEM_ADDRESS = '0; DATA_MEM_WRITEDATA = '0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clear_inputs();
    @(negedge CLK); @(negedge CLK);
    model_reset();
    RESET = 1'b0;
  endtask

  typedef struct {
    logic              i_rd;
    logic [ADDR_W-1:0] i_addr;
    logic              d_rd, d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              exp_rd, exp_wr;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int i_gap, d_gap, i_wait, d_wait, kind;

    // Sequence starts from reset (last grant = D, so I wins the first tie).
    vecs[0] = '{1, 28'h10, 0, 0, 28'h0,  '0,                  1, 0, 28'h10};
    vecs[1] = '{0, 28'h0,  1, 0, 28'h20, '0,                  1, 0, 28'h20};
    vecs[2] = '{1, 28'h11, 1, 0, 28'h22, '0,                  1, 0, 28'h11};
    vecs[3] = '{1, 28'h12, 0, 1, 28'h23, {16{8'h11}},         1, 0, 28'h12};
    vecs[4] = '{1, 28'h13, 0, 0, 28'h0,  '0,                  1, 0, 28'h13};
    vecs[5] = '{1, 28'h14, 1, 1, 28'h30, {16{8'hA5}},         0, 1, 28'h30};
    vecs[6] = '{0, 28'h0,  0, 1, 28'h31, {16{8'h5A}},         0, 1, 28'h31};
    vecs[7] = '{1, 28'h15, 1, 0, 28'h30, '0,                  1, 0, 28'h15};

    i_done_cnt = 0; d_done_cnt = 0;
    RESET = 1'b1;
    clear_inputs();
    @(negedge CLK);
    check("rst_mem_read", MEM_READ, 0);
    check("rst_mem_write", MEM_WRITE, 0);
    check("rst_mem_addr", MEM_ADDRESS, 0);
    check("rst_mem_wdata", MEM_WRITEDATA, 0);
    check("rst_i_busy", INST_MEM_BUSYWAIT, 0);
    check("rst_d_busy", DATA_MEM_BUSYWAIT, 0);
    @(negedge CLK);
    model_reset();
    RESET = 1'b0;

    // Lone I-read, memory busy for 5 cycles: grant on the first edge, memory
    // raises busy one edge later, so the stall falls 6 samples after the grant.
    mem_lat = 5;
    INST_MEM_ADDRESS = 28'h10; INST_MEM_READ = 1'b1;
    tick();
    check("t1_read_after_1cyc", MEM_READ, 1);
    n = 0;
    while (INST_MEM_BUSYWAIT && n < 50) begin tick(); n++; end
    check("t1_latency", n, 6);
    check("t1_addr", MEM_ADDRESS, 28'h10);
    check("t1_mem_idle", MEM_BUSYWAIT, 0);
    INST_MEM_READ = 1'b0;
    tick();
    check("t1_cmd_cleared", MEM_READ, 0);
    tick();

    // Simultaneous I and D reads right after reset.
    do_reset();
    mem_lat = 3;
    INST_MEM_ADDRESS = 28'h10; INST_MEM_READ = 1'b1;
    DATA_MEM_ADDRESS = 28'h20; DATA_MEM_READ = 1'b1;
    tick();
    check("t2_i_first", MEM_ADDRESS, 28'h10);
    n = 0;
    while (INST_MEM_BUSYWAIT && n < 50) begin
      check("t2_d_stalled", DATA_MEM_BUSYWAIT, 1);
      tick(); n++;
    end
    INST_MEM_READ = 1'b0;
    n = 0;
    do begin
      tick(); n++;
      check("t2_d_stalled_rel", DATA_MEM_BUSYWAIT, 1);
    end while (!MEM_READ && n < 20);
    check("t2_d_grant_gap", n, 3);
    check("t2_d_addr", MEM_ADDRESS, 28'h20);
    run_until_idle();

    // Table of grant decisions.
    do_reset();
    for (int v = 0; v < 8; v++) begin
      mem_lat = 1 + (v % 4);
      INST_MEM_READ = vecs[v].i_rd; INST_MEM_ADDRESS = vecs[v].i_addr;
      DATA_MEM_READ = vecs[v].d_rd; DATA_MEM_WRITE = vecs[v].d_wr;
      DATA_MEM_ADDRESS = vecs[v].d_addr; DATA_MEM_WRITEDATA = vecs[v].d_wdata;
      tick();
      check($sformatf("vec%0d_read", v), MEM_READ, vecs[v].exp_rd);
      check($sformatf("vec%0d_write", v), MEM_WRITE, vecs[v].exp_wr);
      check($sformatf("vec%0d_addr", v), MEM_ADDRESS, vecs[v].exp_addr);
      if (vecs[v].exp_wr) check($sformatf("vec%0d_wdata", v), MEM_WRITEDATA, vecs[v].d_wdata);
      drop_done();
      run_until_idle();
    end

    // D-cache moves its address mid-transfer; memory keeps the latched one.
    mem_lat = 4;
    DATA_MEM_ADDRESS = 28'h07; DATA_MEM_READ = 1'b1;
    tick();
    check("t4_addr_latched", MEM_ADDRESS, 28'h07);
    DATA_MEM_ADDRESS = 28'h09;
    n = 0;
    while (DATA_MEM_BUSYWAIT && n < 50) begin
      tick(); n++;
      check("t4_addr_held", MEM_ADDRESS, 28'h07);
    end
    check("t4_done_bound", n < 50, 1);
    DATA_MEM_READ = 1'b0;
    tick(); tick();

    // Reset during SERVE_D aborts at once; next tie goes to I.
    mem_lat = 6;
    DATA_MEM_ADDRESS = 28'h40; DATA_MEM_READ = 1'b1;
    tick(); tick(); tick();
    check("t5_serving", MEM_READ, 1);
    #2 RESET = 1'b1;
    #1;
    check("t5_async_read", MEM_READ, 0);
    check("t5_async_write", MEM_WRITE, 0);
    @(negedge CLK);
    model_reset();
    RESET = 1'b0;
    INST_MEM_ADDRESS = 28'h41; INST_MEM_READ = 1'b1;
    tick();
    check("t5_tie_to_i", MEM_ADDRESS, 28'h41);
    check("t5_tie_read", MEM_READ, 1);
    run_until_idle();

    // Random traffic against the reference model.
    do_reset();
    i_done_cnt = 0; d_done_cnt = 0;
    i_gap = 0; d_gap = 0; i_wait = 0; d_wait = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      if (INST_MEM_READ) begin
        if (!INST_MEM_BUSYWAIT) begin
          check("rand_i_wait_bound", i_wait < 40, 1);
          INST_MEM_READ = 1'b0; i_gap = $urandom_range(0, 3);
        end else i_wait++;
      end else if (i_gap > 0) i_gap--;
      else begin
        INST_MEM_READ = 1'b1; INST_MEM_ADDRESS = 28'($urandom_range(0, 255)); i_wait = 0;
      end
      if (DATA_MEM_READ || DATA_MEM_WRITE) begin
        if (!DATA_MEM_BUSYWAIT) begin
          check("rand_d_wait_bound", d_wait < 40, 1);
          DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0; d_gap = $urandom_range(0, 3);
        end else d_wait++;
      end else if (d_gap > 0) d_gap--;
      else begin
        kind = $urandom_range(0, 2);
        DATA_MEM_READ = (kind != 1); DATA_MEM_WRITE = (kind != 0);
        DATA_MEM_ADDRESS = 28'($urandom_range(0, 255));
        DATA_MEM_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
        d_wait = 0;
      end
      mem_lat = $urandom_range(1, 6);
    end
    run_until_idle();
    check("rand_i_progress", i_done_cnt > 20, 1);
    check("rand_d_progress", d_done_cnt > 20, 1);

`ifdef ARB_STATS_EN
    do_reset();
    check("stat_rst_i", STAT_I_GRANTS, 0);
    check("stat_rst_d", STAT_D_GRANTS, 0);
    check("stat_rst_c", STAT_CONFLICTS, 0);
    mem_lat = 2;
    for (int r = 0; r < 23; r++) begin
      INST_MEM_ADDRESS = 28'h1; INST_MEM_READ = 1'b1;
      DATA_MEM_ADDRESS = 28'h2; DATA_MEM_READ = 1'b1;
      run_until_idle();
      if (r == 2) begin
        check("stat3_i", STAT_I_GRANTS, 3);
        check("stat3_d", STAT_D_GRANTS, 3);
        check("stat3_c_ge3", STAT_CONFLICTS >= 3, 1);
      end
    end
    check("stat_sat_i", STAT_I_GRANTS, {TB_STAT_W{1'b1}});
    check("stat_sat_d", STAT_D_GRANTS, {TB_STAT_W{1'b1}});
    check("stat_sat_c", STAT_CONFLICTS, {TB_STAT_W{1'b1}});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
